// File: rtl/mips_mem_pkg.sv
// Shared memory-subsystem types: grant encoding and default RAM geometry
// used by the port arbiter and the ram instance it feeds.
package mips_mem_pkg;

   localparam int MEM_WIDTH = 32;
   localparam int MEM_DEPTH = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SRV_IF = 2'b01,
      SRV_DM = 2'b10
   } grant_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles a fetch request lost arbitration;
// at_limit tells the arbiter to let the fetch port win.
module arb_starve_ctr #(
   parameter int LIMIT = 4,
   localparam int CW   = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign at_limit = (cnt_q == CW'(LIMIT));

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && !at_limit)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one combinational-read ram between fetch and data-memory stages:
// one grant per cycle, ack and registered read data on the following cycle.
module mem_port_arbiter
   import mips_mem_pkg::*;
#(
   parameter int WIDTH        = MEM_WIDTH,
   parameter int DEPTH        = MEM_DEPTH,
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             if_req,
   input  logic [DEPTH-1:0] if_addr,
   output logic             if_ack,
   output logic [WIDTH-1:0] if_rdata,
   input  logic             dm_req,
   input  logic             dm_we,
   input  logic [DEPTH-1:0] dm_addr,
   input  logic [WIDTH-1:0] dm_wdata,
   output logic             dm_ack,
   output logic [WIDTH-1:0] dm_rdata,
   output logic             ram_ena,
   output logic             ram_wena,
   output logic [DEPTH-1:0] ram_addr,
   output logic [WIDTH-1:0] ram_wdata,
   input  logic [WIDTH-1:0] ram_rdata
);

   grant_e           grant_q;
   grant_e           grant_d;
   logic [WIDTH-1:0] if_rdata_q;
   logic [WIDTH-1:0] dm_rdata_q;
   logic             at_limit;
   logic             grant_if;
   logic             grant_dm;

   // Data port wins contention unless fetch has been starved long enough
   assign grant_if = if_req & (~dm_req | at_limit);
   assign grant_dm = dm_req & ~grant_if;

   assign ram_ena   = (grant_if | grant_dm) & rst_n;
   assign ram_wena  = grant_dm & dm_we & rst_n;
   assign ram_addr  = grant_if ? if_addr : dm_addr;
   assign ram_wdata = dm_wdata;

   arb_starve_ctr #(
      .LIMIT(STARVE_LIMIT)
   ) u_starve (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (if_req & grant_dm),
      .clr     (~if_req | grant_if),
      .at_limit(at_limit)
   );

   always_comb begin
      grant_d = IDLE;
      unique case (1'b1)
         grant_if: grant_d = SRV_IF;
         grant_dm: grant_d = SRV_DM;
         default:  grant_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q    <= IDLE;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         grant_q <= grant_d;
         if (grant_if)
            if_rdata_q <= ram_rdata;
         if (grant_dm && !dm_we)
            dm_rdata_q <= ram_rdata;
      end
   end

   assign if_ack   = (grant_q == SRV_IF);
   assign dm_ack   = (grant_q == SRV_DM);
   assign if_rdata = if_rdata_q;
   assign dm_rdata = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a
// transaction-level model of the arbitration rules and a shadow memory.
module tb_mem_port_arbiter;

   localparam int W   = 32;
   localparam int D   = 10;
   localparam int LIM = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         if_req;
   logic [D-1:0] if_addr;
   logic         if_ack;
   logic [W-1:0] if_rdata;
   logic         dm_req;
   logic         dm_we;
   logic [D-1:0] dm_addr;
   logic [W-1:0] dm_wdata;
   logic         dm_ack;
   logic [W-1:0] dm_rdata;
   logic         ram_ena;
   logic         ram_wena;
   logic [D-1:0] ram_addr;
   logic [W-1:0] ram_wdata;
   logic [W-1:0] ram_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .WIDTH       (W),
      .DEPTH       (D),
      .STARVE_LIMIT(LIM)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_ack   (if_ack),
      .if_rdata (if_rdata),
      .dm_req   (dm_req),
      .dm_we    (dm_we),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_ack   (dm_ack),
      .dm_rdata (dm_rdata),
      .ram_ena  (ram_ena),
      .ram_wena (ram_wena),
      .ram_addr (ram_addr),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   // ram instance stand-in: write on the edge, combinational read
   logic [W-1:0] mem     [1024];
   logic [W-1:0] ref_mem [1024];

   assign ram_rdata = mem[ram_addr];

   always @(posedge clk)
      if (ram_ena && ram_wena)
         mem[ram_addr] <= ram_wdata;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Model: 0 = no grant, 1 = fetch, 2 = data
   int           denied   = 0;
   int           last_g   = 0;
   logic         e_if_ack = 1'b0;
   logic         e_dm_ack = 1'b0;
   logic [W-1:0] e_if_rd  = '0;
   logic [W-1:0] e_dm_rd  = '0;

   function automatic int pick();
      if (dm_req && !(if_req && denied >= LIM)) return 2;
      if (if_req) return 1;
      return 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      int g;
      if (!rst_n) begin
         denied   <= 0;
         last_g   <= 0;
         e_if_ack <= 1'b0;
         e_dm_ack <= 1'b0;
         e_if_rd  <= '0;
         e_dm_rd  <= '0;
      end else begin
         g = pick();
         last_g   <= g;
         e_if_ack <= (g == 1);
         e_dm_ack <= (g == 2);
         if (g == 1)
            e_if_rd <= ref_mem[if_addr];
         if (g == 2 && !dm_we)
            e_dm_rd <= ref_mem[dm_addr];
         if (g == 2 && dm_we)
            ref_mem[dm_addr] <= dm_wdata;
         if (if_req && g == 2)
            denied <= (denied < LIM) ? denied + 1 : LIM;
         else
            denied <= 0;
      end
   end

   always @(negedge clk) begin : compare
      int g;
      chk("if_ack", W'(if_ack), W'(e_if_ack));
      chk("dm_ack", W'(dm_ack), W'(e_dm_ack));
      chk("if_rdata", if_rdata, e_if_rd);
      chk("dm_rdata", dm_rdata, e_dm_rd);
      if (rst_n) begin
         g = pick();
         chk("ram_ena", W'(ram_ena), W'(g != 0));
         chk("ram_wena", W'(ram_wena), W'(g == 2 && dm_we));
         if (g == 1) chk("ram_addr_if", W'(ram_addr), W'(if_addr));
         if (g == 2) chk("ram_addr_dm", W'(ram_addr), W'(dm_addr));
         if (g == 2 && dm_we) chk("ram_wdata", ram_wdata, dm_wdata);
      end else begin
         chk("rst_ram_ena", W'(ram_ena), '0);
         chk("rst_ram_wena", W'(ram_wena), '0);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [9:0] pat = 10'b10_0001_0000;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i]     = 32'hA500_0000 | W'(i);
         ref_mem[i] = 32'hA500_0000 | W'(i);
      end
      mem[5]     = 32'h2402_000A;
      ref_mem[5] = 32'h2402_000A;

      rst_n    = 1'b0;
      if_req   = 1'b1;
      if_addr  = '0;
      dm_req   = 1'b1;
      dm_we    = 1'b0;
      dm_addr  = '0;
      dm_wdata = '0;
      repeat (2) cyc();
      chk("reset ram_ena", W'(ram_ena), '0);
      chk("reset ram_wena", W'(ram_wena), '0);
      chk("reset if_ack", W'(if_ack), '0);
      chk("reset dm_ack", W'(dm_ack), '0);
      chk("reset if_rdata", if_rdata, '0);
      chk("reset dm_rdata", dm_rdata, '0);
      rst_n = 1'b1;
      cyc();
      chk("first grant dm_ack", W'(dm_ack), 1);
      chk("first grant if_ack", W'(if_ack), 0);
      chk("first grant dm_rdata", dm_rdata, 32'hA500_0000);

      if_req = 1'b0;
      dm_req = 1'b0;
      cyc();

      if_req  = 1'b1;
      if_addr = 10'd5;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("if_only ack", W'(if_ack), 1);
         chk("if_only rdata", if_rdata, 32'h2402_000A);
      end
      if_req = 1'b0;

      dm_req   = 1'b1;
      dm_we    = 1'b1;
      dm_addr  = 10'd7;
      dm_wdata = 32'hDEAD_BEEF;
      cyc();
      chk("store ack", W'(dm_ack), 1);
      chk("store keeps dm_rdata", dm_rdata, 32'hA500_0000);
      dm_we = 1'b0;
      cyc();
      chk("load ack", W'(dm_ack), 1);
      chk("load rdata", dm_rdata, 32'hDEAD_BEEF);

      dm_we    = 1'b1;
      dm_addr  = 10'd3;
      dm_wdata = 32'h0000_1234;
      cyc();
      dm_req  = 1'b0;
      dm_we   = 1'b0;
      if_req  = 1'b1;
      if_addr = 10'd3;
      cyc();
      chk("hazard if_ack", W'(if_ack), 1);
      chk("hazard if_rdata", if_rdata, 32'h0000_1234);
      if_req = 1'b0;
      cyc();

      dm_req  = 1'b1;
      dm_addr = 10'd1;
      if_req  = 1'b1;
      if_addr = 10'd2;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("starve if_ack", W'(if_ack), W'(pat[i]));
         chk("starve dm_ack", W'(dm_ack), W'(!pat[i]));
      end
      dm_req = 1'b0;
      if_req = 1'b0;
      cyc();

      dm_req   = 1'b1;
      dm_we    = 1'b1;
      dm_addr  = 10'd9;
      dm_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      #1 rst_n = 1'b0;
      cyc();
      chk("midrst dm_ack", W'(dm_ack), 0);
      chk("midrst mem", mem[9], 32'hA500_0009);
      chk("midrst state", W'(dut.grant_q), 0);
      dm_req = 1'b0;
      dm_we  = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();

      for (int i = 0; i < 400; i++) begin
         if (!if_req || last_g == 1) begin
            if_req  = ($urandom % 4) != 0;
            if_addr = D'($urandom_range(0, 15));
         end else if ($urandom % 8 == 0) begin
            if_req = 1'b0;
         end
         if (!dm_req || last_g == 2) begin
            dm_req   = ($urandom % 4) != 0;
            dm_we    = $urandom % 2;
            dm_addr  = D'($urandom_range(0, 15));
            dm_wdata = $urandom;
         end else if ($urandom % 8 == 0) begin
            dm_req = 1'b0;
         end
         cyc();
      end
      if_req = 1'b0;
      dm_req = 1'b0;
      repeat (2) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter that shares the single-port instruction/data `ram` between the instruction-fetch stage (read-only) and the data-memory stage (load/store). It sits between the CPU pipeline and one `ram` instance configured with the combinational-read (normal) mode. It grants one access per cycle and returns read data and a one-cycle `ack` to the winning requester on the next cycle. Data port has priority, with a starvation guard that forces a fetch grant.

## Interface
- `WIDTH`, 32, data word width; equals `ram` `WIDTH`
- `DEPTH`, 10, word-address bits; equals `ram` `DEPTH`
- `STARVE_LIMIT`, 4, consecutive denied fetch cycles before fetch is forced to win (1..15)

- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `if_req` in 1: fetch read request
- `if_addr` in DEPTH: fetch word address
- `if_ack` out 1: one-cycle pulse, `if_rdata` valid
- `if_rdata` out WIDTH: fetched word, registered
- `dm_req` in 1: data request
- `dm_we` in 1: 1 = store, 0 = load
- `dm_addr` in DEPTH: data word address
- `dm_wdata` in WIDTH: store data
- `dm_ack` out 1: one-cycle pulse, access complete
- `dm_rdata` out WIDTH: load data, registered
- `ram_ena` out 1: to `ram.ram_ena`
- `ram_wena` out 1: to `ram.wena`
- `ram_addr` out DEPTH: to `ram.addr`
- `ram_wdata` out WIDTH: to `ram.data_in`
- `ram_rdata` in WIDTH: from `ram.data_out`, combinational

## Operation
- The arbitration cycle (cycle N) is combinational from the `*_req` inputs, `grant_q`, and `starve_q`. The RAM port is driven in the same cycle from the winner.
- Grant rule:
  - Only `dm_req` is high: DM wins.
  - Only `if_req` is high: IF wins.
  - Both are high: DM wins, unless `starve_q == STARVE_LIMIT`, in which case IF wins.
  - Neither is high: no grant, and `ram_ena = 0`.
- RAM drive:
  - IF win: `ram_ena=1`, `ram_wena=0`, `ram_addr=if_addr`.
  - DM win: `ram_ena=1`, `ram_wena=dm_we`, `ram_addr=dm_addr`, `ram_wdata=dm_wdata`.
  - No grant: `ram_wena=0`. `ram_addr` and `ram_wdata` hold the DM values (don't-care).
- `ram_ena` and `ram_wena` are additionally ANDed with `rst_n`, so no RAM write occurs while reset is asserted.
- FSM register `grant_q` records the cycle-N owner for cycle N+1. States:
  - IDLE: no grant
  - SRV_IF: IF owned cycle N
  - SRV_DM: DM owned cycle N
  - Transitions follow the grant rule every cycle. Back-to-back grants go directly SRV_x→SRV_y with no IDLE between.
- Ack and data in cycle N+1:
  - SRV_IF: `if_ack=1`; `if_rdata` holds the `ram_rdata` captured at the N→N+1 edge.
  - SRV_DM: `dm_ack=1`. On a load, `dm_rdata` is captured at the same edge. On a store, `dm_rdata` holds its previous value.
  - The other port's rdata holds.
- Handshake:
  - The requester holds `req`, address, `we` and `wdata` stable until it sees `ack`.
  - `req` sampled in the same cycle as `ack` is a new request, so a port can be granted every cycle.
  - Deasserting `req` before `ack` withdraws the request; the arbiter keeps no memory of it.
- Starvation counter `starve_q`:
  - Increments, saturating at `STARVE_LIMIT`, when `if_req` is high and DM wins.
  - Clears to 0 when IF wins or `if_req` is low.
  - Width: `$clog2(STARVE_LIMIT+1)`.

## Timing
- Reset values: `grant_q=IDLE`, `starve_q=0`, `if_ack=0`, `dm_ack=0`, `if_rdata=0`, `dm_rdata=0`.
- While `rst_n` is low, `ram_ena=0` and `ram_wena=0`.
- Reset asserted mid-access: the in-flight ack is lost (forced 0), the write is suppressed if `rst_n` is low at the edge, and the requester must re-issue.
- Latency: request in cycle N, then `ack` and data in N+1. Throughput is 1 access/cycle total.
- Write-then-read of the same address: a DM store granted in N followed by an IF or DM read in N+1 returns the new data, because the RAM writes at the edge and reads combinationally.
- The combinational path runs from `*_req`/`*_addr` through `ram_addr` and `ram_rdata` to the rdata registers. The arbiter adds no registers on the RAM side.

## Structure
- Shared package `mips_mem_pkg`:
  - grant state encoding (`IDLE=2'b00`, `SRV_IF=2'b01`, `SRV_DM=2'b10`)
  - default `WIDTH`/`DEPTH` constants, shared with `ram` instantiation
- One natural sub-module: `arb_starve_ctr`, the saturating counter with `inc`/`clr` inputs and an `at_limit` output.
- The FSM, grant mux and rdata/ack registers live in the top.

## Test plan
- Reset: hold `rst_n=0` with both req high, then check `ram_ena=0`, both acks 0, both rdata 0. Release; first grant goes to DM.
- IF only: `if_req=1`, `if_addr=5`, RAM[5]=`0x2402000A`. Check `if_ack` in the next cycle with `if_rdata=0x2402000A`. Keep req high for 3 cycles and check 3 consecutive acks.
- DM store then load: store `0xDEADBEEF` to addr 7, then load addr 7 the next cycle. Check `dm_ack` for both accesses, `dm_rdata=0xDEADBEEF`, and `dm_rdata` unchanged after the store ack.
- Contention with starvation, `STARVE_LIMIT=4`: hold `dm_req` and `if_req` continuously. DM is granted 4 cycles, IF the 5th, then DM 4 more, and the pattern repeats.
- Store/fetch hazard: DM stores `0x1234` to addr 3 in cycle N, and IF reads addr 3 in N+1. Check `if_rdata=0x1234`.
- Mid-operation reset: pull `rst_n` low in the cycle a DM store is granted. Check that RAM[addr] is unchanged, `dm_ack` never pulses, and the state returns to IDLE.
